// File: rtl/if_id_stage_pkg.sv
// Shared pipeline definitions: FSM encodings, reset defaults and small helpers
// used by the IF/ID, ID/EX and EX/MEM stages.
package if_id_stage_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } pipe_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    // Event counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/if_id_stage_load_use_detect.sv
// Purely combinational load-use hazard detector: a load in ID/EX whose
// destination feeds either source register of the instruction in IF/ID.
module load_use_detect (
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       ex_mem2r_i,
    input  logic [4:0] ex_rt_i,
    output logic       hazard_o
);

    // Register zero is hardwired, so a load targeting it never creates a dependency.
    assign hazard_o = id_valid_i & ex_mem2r_i & (ex_rt_i != 5'd0) &
                      ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register with load-use stall, EX redirect
// flush, a RUN/STALL/FLUSH status FSM and saturating stall/flush counters.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_instr,
    input  logic        ex_mem2r,
    input  logic [4:0]  ex_rt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        bubble,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    pipe_state_e state_q, state_d;
    logic [31:0] pc_plus4;
    logic        hazard;

    load_use_detect u_load_use_detect (
        .id_valid_i (id_valid_q),
        .id_rs_i    (id_instr_q[25:21]),
        .id_rt_i    (id_instr_q[20:16]),
        .ex_mem2r_i (ex_mem2r),
        .ex_rt_i    (ex_rt),
        .hazard_o   (hazard)
    );

    assign pc_plus4 = pc_q + 32'd4;

    // Redirect beats hazard: the stalled instruction is on the wrong path anyway.
    always_comb begin
        pc_d       = pc_q;
        id_pc4_d   = id_pc4_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            id_pc4_d   = 32'd0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (!hazard) begin
            pc_d       = pc_plus4;
            id_pc4_d   = pc_plus4;
            id_instr_d = imem_instr;
            id_valid_d = 1'b1;
        end
    end

    always_comb begin
        if (redirect_valid) begin
            state_d = ST_FLUSH;
        end else if (hazard) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        stall_cnt_d = (state_d == ST_STALL) ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = (state_d == ST_FLUSH) ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            id_pc4_q    <= 32'd0;
            id_instr_q  <= NOP_INSTR;
            id_valid_q  <= 1'b0;
            state_q     <= ST_RUN;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            pc_q        <= pc_d;
            id_pc4_q    <= id_pc4_d;
            id_instr_q  <= id_instr_d;
            id_valid_q  <= id_valid_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Unused encoding 3 is reported as RUN.
    always_comb begin
        bubble = hazard | redirect_valid;
        case (state_q)
            ST_STALL: state = 2'd1;
            ST_FLUSH: state = 2'd2;
            default:  state = 2'd0;
        endcase
    end

    assign pc        = pc_q;
    assign id_pc4    = id_pc4_q;
    assign id_instr  = id_instr_q;
    assign id_valid  = id_valid_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
